// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable integer clock divider with glitch-free divisor reload
module clk_div_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             load_ack,
    output logic             load_err,
    output logic [WIDTH-1:0] div_active,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] pending, pending_next;
    logic [WIDTH-1:0] div_active_next;
    logic             pend, pend_next;
    logic             clk_out_next, tick_next, load_ack_next, load_err_next;
    logic             load_ok, boundary;

    // A divisor below 2 cannot form a clock, so such loads are rejected.
    assign load_ok  = div_load && (div_val >= WIDTH'(2));
    // Last count of the current period; divisor swaps happen only here.
    assign boundary = (cnt == div_active - WIDTH'(1));
    assign running  = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter, registered outputs and divisor bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            clk_out    <= 1'b0;
            tick       <= 1'b0;
            load_ack   <= 1'b0;
            load_err   <= 1'b0;
            pend       <= 1'b0;
            pending    <= DEF_DIV;
            div_active <= DEF_DIV;
        end else begin
            cnt        <= cnt_next;
            clk_out    <= clk_out_next;
            tick       <= tick_next;
            load_ack   <= load_ack_next;
            load_err   <= load_err_next;
            pend       <= pend_next;
            pending    <= pending_next;
            div_active <= div_active_next;
        end
    end

    // Next-state, next-count and divisor-apply decisions.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        clk_out_next    = clk_out;
        tick_next       = 1'b0;
        load_ack_next   = 1'b0;
        load_err_next   = div_load && !load_ok;
        pending_next    = pending;
        pend_next       = pend;
        div_active_next = div_active;

        case (state)
            IDLE: begin
                cnt_next     = '0;
                clk_out_next = 1'b0;
                if (pend) begin
                    div_active_next = pending;
                    pend_next       = 1'b0;
                    load_ack_next   = 1'b1;
                end
                if (en) begin
                    state_next   = RUN;
                    clk_out_next = 1'b1;
                    tick_next    = 1'b1;
                end
            end
            RUN, DRAIN: begin
                if (boundary) begin
                    cnt_next = '0;
                    if (pend) begin
                        div_active_next = pending;
                        pend_next       = 1'b0;
                        load_ack_next   = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + WIDTH'(1);
                end
                // High phase is the first floor(N/2) counts of the period in force.
                clk_out_next = (cnt_next < (div_active_next >> 1));
                tick_next    = (cnt_next == '0);
                if (en) begin
                    state_next = RUN;
                end else if (state == RUN) begin
                    state_next = DRAIN;
                end else if (boundary) begin
                    state_next   = IDLE;
                    clk_out_next = 1'b0;
                    tick_next    = 1'b0;
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                clk_out_next = 1'b0;
            end
        endcase

        // Capture after the apply step so a load on the boundary waits for the next one.
        if (load_ok) begin
            pending_next = div_val;
            pend_next    = 1'b1;
        end
    end

endmodule
